// File: rtl/bin_to_bcd_3digit_seq.sv
// Sequential double-dabble binary-to-BCD converter, one operand bit per clock.
// Latency BIN_W cycles from the accepting edge; start is ignored while busy.
module bin_to_bcd_3digit_seq #(
    parameter int BIN_W  = 10,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int SH_W  = 4 * (DIGITS + 1);
    localparam int OUT_W = 4 * DIGITS;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     bin_sh_q, bin_sh_d;
    logic [SH_W-1:0]      bcd_sh_q, bcd_sh_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_W-1:0]     bcd_out_q, bcd_out_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [SH_W-1:0]       bcd_corr;
    logic [SH_W+BIN_W-1:0] word_sh;
    logic [SH_W-1:0]       bcd_step;
    logic [BIN_W-1:0]      bin_step;

    // Add-3 correction on every nibble (guard included), then one left shift of
    // the concatenated scratch/operand word.
    always_comb begin
        bcd_corr = bcd_sh_q;
        for (int i = 0; i < DIGITS + 1; i++) begin
            if (bcd_sh_q[4*i +: 4] >= 4'd5) begin
                bcd_corr[4*i +: 4] = bcd_sh_q[4*i +: 4] + 4'd3;
            end
        end
        word_sh  = {bcd_corr, bin_sh_q} << 1;
        bcd_step = word_sh[BIN_W +: SH_W];
        bin_step = word_sh[BIN_W-1:0];
    end

    always_comb begin
        state_d   = state_q;
        bin_sh_d  = bin_sh_q;
        bcd_sh_d  = bcd_sh_q;
        cnt_d     = cnt_q;
        bcd_out_d = bcd_out_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bin_sh_d = bin_in;
                    bcd_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = CONV;
                end
            end
            CONV: begin
                bin_sh_d = bin_step;
                bcd_sh_d = bcd_step;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    bcd_out_d = bcd_step[OUT_W-1:0];
                    ovf_d     = |bcd_step[SH_W-1:OUT_W];
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bin_sh_q  <= '0;
            bcd_sh_q  <= '0;
            cnt_q     <= '0;
            bcd_out_q <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bin_sh_q  <= bin_sh_d;
            bcd_sh_q  <= bcd_sh_d;
            cnt_q     <= cnt_d;
            bcd_out_q <= bcd_out_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign bcd_out = bcd_out_q;
    assign ovf     = ovf_q;

endmodule
